// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for sprite motion controllers: default screen geometry
// and the motion FSM state encoding.
package sprite_motion_ctrl_pkg;

  localparam int unsigned SCREEN_W_PX = 640;  // visible width in pixels
  localparam int unsigned SCREEN_H_LN = 480;  // visible height in lines

  typedef enum logic [2:0] {
    MOVE_R,
    MOVE_L,
    DROP_R,
    DROP_L,
    LANDED
  } spr_state_e;

endpackage

// File: rtl/sprite_motion_ctrl_frame_tick_gen.sv
// frame_tick_gen: detects entry of the VGA row counter into the first
// blanking line and divides the resulting frame ticks by FRAME_DIV.
//   i_clk, i_rst_n : clock, async active-low reset
//   yy             : current VGA row
//   i_enable       : divider counts ticks only while high
//   i_clear        : synchronous divider clear (respawn)
//   o_frame_tick   : one-cycle pulse, cycle after yy enters SCREEN_H
//   o_update       : combinational, high in the tick cycle that wraps the divider
module frame_tick_gen #(
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned FRAME_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] yy,
  input  logic       i_enable,
  input  logic       i_clear,
  output logic       o_frame_tick,
  output logic       o_update
);

  localparam int unsigned      CW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic [9:0]       H_LINE   = 10'(SCREEN_H);

  logic [9:0]    yy_q, yy_d;
  logic          armed_q, armed_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    yy_d     = yy;
    // yy_q is only trusted once a non-blanking-entry line has been seen
    // after reset; otherwise a reset with yy parked on SCREEN_H would
    // fake an edge against the zero reset value of yy_q.
    armed_d  = armed_q | (yy != H_LINE);
    tick_d   = armed_q && (yy == H_LINE) && (yy_q != H_LINE);
    cnt_d    = cnt_q;
    o_update = 1'b0;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && tick_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        o_update = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      yy_q    <= '0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      yy_q    <= yy_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_frame_tick = tick_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame motion sequencer for the bee sprite.
// Sweeps horizontally, drops STEP_Y at each screen edge, lands at Y_LIMIT.
// Position changes only in the cycle after a frame tick (vertical blanking).
//   i_clk, i_rst_n : clock, async active-low reset
//   xx, yy         : current VGA column / row (only yy drives timing)
//   i_enable       : motion and divider run while high
//   i_hit          : one-cycle respawn pulse, highest priority
//   o_spr_x/o_spr_y: sprite top-left position
//   o_dir_left     : high in MOVE_L and DROP_R
//   o_landed       : high in LANDED
//   o_frame_tick   : one pulse per frame
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int unsigned X_START   = 300,
  parameter int unsigned Y_START   = 100,
  parameter int unsigned SPR_W     = 34,
  parameter int unsigned SCREEN_W  = SCREEN_W_PX,
  parameter int unsigned SCREEN_H  = SCREEN_H_LN,
  parameter int unsigned STEP_X    = 2,
  parameter int unsigned STEP_Y    = 8,
  parameter int unsigned Y_LIMIT   = 400,
  parameter int unsigned FRAME_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       i_enable,
  input  logic       i_hit,
  output logic [9:0] o_spr_x,
  output logic [9:0] o_spr_y,
  output logic       o_dir_left,
  output logic       o_landed,
  output logic       o_frame_tick
);

  localparam logic [9:0]  X_RST    = 10'(X_START);
  localparam logic [9:0]  Y_RST    = 10'(Y_START);
  localparam logic [10:0] X_MAX_W  = 11'(SCREEN_W - SPR_W);
  localparam logic [9:0]  X_MAX    = 10'(SCREEN_W - SPR_W);
  localparam logic [10:0] STEP_X_W = 11'(STEP_X);
  localparam logic [9:0]  STEP_X_N = 10'(STEP_X);
  localparam logic [10:0] STEP_Y_W = 11'(STEP_Y);
  localparam logic [10:0] Y_LIM_W  = 11'(Y_LIMIT);
  localparam logic [9:0]  Y_LIM    = 10'(Y_LIMIT);

  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  spr_state_e  state_q, state_d;
  logic [10:0] x_inc, y_inc;
  logic [9:0]  x_dec;
  logic        update;
  logic        unused_xx;

  assign unused_xx = ^xx;

  frame_tick_gen #(
    .SCREEN_H  (SCREEN_H),
    .FRAME_DIV (FRAME_DIV)
  ) u_tick (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .yy           (yy),
    .i_enable     (i_enable),
    .i_clear      (i_hit),
    .o_frame_tick (o_frame_tick),
    .o_update     (update)
  );

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    state_d = state_q;
    x_inc   = {1'b0, x_q} + STEP_X_W;
    x_dec   = x_q - STEP_X_N;
    y_inc   = {1'b0, y_q} + STEP_Y_W;
    if (i_hit) begin
      x_d     = X_RST;
      y_d     = Y_RST;
      state_d = MOVE_R;
    end else if (update) begin
      case (state_q)
        MOVE_R: begin
          if (x_inc >= X_MAX_W) begin
            x_d     = X_MAX;
            state_d = DROP_L;
          end else begin
            x_d = x_inc[9:0];
          end
        end
        MOVE_L: begin
          if ({1'b0, x_q} <= STEP_X_W) begin
            x_d     = '0;
            state_d = DROP_R;
          end else begin
            x_d = x_dec;
          end
        end
        DROP_L, DROP_R: begin
          if (y_inc >= Y_LIM_W) begin
            y_d     = Y_LIM;
            state_d = LANDED;
          end else begin
            y_d     = y_inc[9:0];
            state_d = (state_q == DROP_L) ? MOVE_L : MOVE_R;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= X_RST;
      y_q     <= Y_RST;
      state_q <= MOVE_R;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      state_q <= state_d;
    end
  end

  assign o_spr_x    = x_q;
  assign o_spr_y    = y_q;
  assign o_dir_left = (state_q == MOVE_L) || (state_q == DROP_R);
  assign o_landed   = (state_q == LANDED);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Four controllers run side by side on one VGA row stream:
//   0: defaults (FRAME_DIV = 2)
//   1: X_START = 604, every frame (right edge and drop)
//   2: 40-wide screen, 37-wide sprite, X_START = 1 (left edge)
//   3: X_START = 604, Y_START = 396, every frame (landing)
module tb_sprite_motion_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [9:0] xx, yy;
  logic       en;
  logic [3:0] hit;
  logic [9:0] sx [4];
  logic [9:0] sy [4];
  logic       dl [4];
  logic       ld [4];
  logic       ft [4];

  always #5 i_clk = ~i_clk;

  sprite_motion_ctrl u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .xx(xx), .yy(yy), .i_enable(en), .i_hit(hit[0]),
    .o_spr_x(sx[0]), .o_spr_y(sy[0]), .o_dir_left(dl[0]), .o_landed(ld[0]), .o_frame_tick(ft[0]));

  sprite_motion_ctrl #(.X_START(604), .FRAME_DIV(1)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .xx(xx), .yy(yy), .i_enable(en), .i_hit(hit[1]),
    .o_spr_x(sx[1]), .o_spr_y(sy[1]), .o_dir_left(dl[1]), .o_landed(ld[1]), .o_frame_tick(ft[1]));

  sprite_motion_ctrl #(.X_START(1), .SPR_W(37), .SCREEN_W(40), .FRAME_DIV(1)) u_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .xx(xx), .yy(yy), .i_enable(en), .i_hit(hit[2]),
    .o_spr_x(sx[2]), .o_spr_y(sy[2]), .o_dir_left(dl[2]), .o_landed(ld[2]), .o_frame_tick(ft[2]));

  sprite_motion_ctrl #(.X_START(604), .Y_START(396), .FRAME_DIV(1)) u_d (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .xx(xx), .yy(yy), .i_enable(en), .i_hit(hit[3]),
    .o_spr_x(sx[3]), .o_spr_y(sy[3]), .o_dir_left(dl[3]), .o_landed(ld[3]), .o_frame_tick(ft[3]));

  // ---------------- behavioural model ----------------
  int P_XS   [4] = '{300, 604, 1, 604};
  int P_YS   [4] = '{100, 100, 100, 396};
  int P_XMAX [4] = '{606, 606, 3, 606};
  int P_DIV  [4] = '{2, 1, 1, 1};

  int m_x [4];
  int m_y [4];
  int m_cnt [4];
  bit m_left [4];   // direction of the most recent horizontal move
  bit m_drop [4];   // a drop is owed before the next horizontal move
  bit m_land [4];
  bit e_tick;
  int m_yyprev;
  bit m_seen_other; // a line other than 480 has been seen since reset

  task automatic m_respawn(input int i);
    m_x[i]    = P_XS[i];
    m_y[i]    = P_YS[i];
    m_cnt[i]  = 0;
    m_left[i] = 1'b0;
    m_drop[i] = 1'b0;
    m_land[i] = 1'b0;
  endtask

  task automatic m_move(input int i);
    if (m_drop[i]) begin
      if (m_y[i] + 8 >= 400) begin
        m_y[i]    = 400;
        m_land[i] = 1'b1;
      end else begin
        m_y[i]    = m_y[i] + 8;
        m_drop[i] = 1'b0;
        m_left[i] = !m_left[i];
      end
    end else if (!m_left[i]) begin
      if (m_x[i] + 2 >= P_XMAX[i]) begin
        m_x[i]    = P_XMAX[i];
        m_drop[i] = 1'b1;
      end else begin
        m_x[i] = m_x[i] + 2;
      end
    end else begin
      if (m_x[i] <= 2) begin
        m_x[i]    = 0;
        m_drop[i] = 1'b1;
      end else begin
        m_x[i] = m_x[i] - 2;
      end
    end
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) m_respawn(i);
      e_tick       = 1'b0;
      m_yyprev     = 0;
      m_seen_other = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) begin
          m_respawn(i);
        end else if (en && e_tick) begin
          if (m_cnt[i] == P_DIV[i] - 1) begin
            m_cnt[i] = 0;
            if (!m_land[i]) m_move(i);
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      e_tick       = (yy == 10'd480) && (m_yyprev != 480) && m_seen_other;
      m_seen_other = m_seen_other || (yy != 10'd480);
      m_yyprev     = int'(yy);
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  int phase = 0;
  int seen_phase = 0;

  // hand-computed positions after frames 1..6
  int LA_X [6] = '{300, 302, 302, 304, 304, 306};
  int LB_X [6] = '{606, 606, 604, 602, 600, 598};
  int LB_Y [6] = '{100, 108, 108, 108, 108, 108};
  int LB_D [6] = '{0, 1, 1, 1, 1, 1};
  int LC_X [6] = '{3, 3, 1, 0, 0, 2};
  int LC_Y [6] = '{100, 108, 108, 108, 116, 116};
  int LC_D [6] = '{0, 1, 1, 1, 0, 0};
  int LD_Y [6] = '{396, 400, 400, 400, 400, 400};
  int LD_L [6] = '{0, 1, 1, 1, 1, 1};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit_check(input int p);
    int f;
    if (p == 1 || p == 40) begin
      chk("rst_ax", int'(sx[0]), 300);
      chk("rst_ay", int'(sy[0]), 100);
      chk("rst_adl", int'(dl[0]), 0);
      chk("rst_ald", int'(ld[0]), 0);
      chk("rst_tick", int'(ft[0]), 0);
      chk("rst_dy", int'(sy[3]), 396);
    end else if (p >= 11 && p <= 16) begin
      f = p - 11;
      chk($sformatf("f%0d_ax", f + 1), int'(sx[0]), LA_X[f]);
      chk($sformatf("f%0d_ay", f + 1), int'(sy[0]), 100);
      chk($sformatf("f%0d_adl", f + 1), int'(dl[0]), 0);
      chk($sformatf("f%0d_bx", f + 1), int'(sx[1]), LB_X[f]);
      chk($sformatf("f%0d_by", f + 1), int'(sy[1]), LB_Y[f]);
      chk($sformatf("f%0d_bdl", f + 1), int'(dl[1]), LB_D[f]);
      chk($sformatf("f%0d_cx", f + 1), int'(sx[2]), LC_X[f]);
      chk($sformatf("f%0d_cy", f + 1), int'(sy[2]), LC_Y[f]);
      chk($sformatf("f%0d_cdl", f + 1), int'(dl[2]), LC_D[f]);
      chk($sformatf("f%0d_dx", f + 1), int'(sx[3]), 606);
      chk($sformatf("f%0d_dy", f + 1), int'(sy[3]), LD_Y[f]);
      chk($sformatf("f%0d_dld", f + 1), int'(ld[3]), LD_L[f]);
    end else if (p == 20) begin
      chk("hold_ax", int'(sx[0]), 306);
    end else if (p == 21) begin
      chk("resume_ax", int'(sx[0]), 308);
    end else if (p == 30) begin
      chk("hitd_x", int'(sx[3]), 604);
      chk("hitd_y", int'(sy[3]), 396);
      chk("hitd_ld", int'(ld[3]), 0);
    end else if (p == 31) begin
      chk("hita_x", int'(sx[0]), 300);
      chk("hita_y", int'(sy[0]), 100);
      chk("hita_dl", int'(dl[0]), 0);
    end else if (p == 33) begin
      chk("divclr_ax", int'(sx[0]), 300);
    end else if (p == 34) begin
      chk("divclr_ax2", int'(sx[0]), 302);
    end else if (p >= 41 && p <= 44) begin
      chk("rst480_notick", int'(ft[0]), 0);
    end else if (p == 50) begin
      chk("reentry_tick", int'(ft[0]), 1);
    end else if (p == 51) begin
      chk("reentry_tick_end", int'(ft[0]), 0);
    end
  endtask

  always @(negedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_x", i), int'(sx[i]), m_x[i]);
      chk($sformatf("u%0d_y", i), int'(sy[i]), m_y[i]);
      chk($sformatf("u%0d_dir", i), int'(dl[i]), int'(m_left[i] && !m_land[i]));
      chk($sformatf("u%0d_land", i), int'(ld[i]), int'(m_land[i]));
      chk($sformatf("u%0d_tick", i), int'(ft[i]), int'(e_tick));
    end
    if (phase != seen_phase) begin
      seen_phase = phase;
      lit_check(phase);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  // One frame's worth of rows around blanking entry; hmask pulses i_hit in
  // the cycle where the frame's update lands.
  task automatic frame(input logic [3:0] hmask);
    yy = 10'd478; cyc(1);
    yy = 10'd479; cyc(1);
    yy = 10'd480; cyc(1);
    hit = hmask;  cyc(1);
    hit = '0;     cyc(1);
    yy = 10'd481; cyc(2);
    yy = 10'd0;   cyc(2);
  endtask

  always @(posedge i_clk) xx <= xx + 10'd1;

  initial begin
    xx = '0; yy = '0; en = 1'b0; hit = '0; i_rst_n = 1'b0;
    cyc(3);
    phase = 1;
    cyc(1);
    i_rst_n = 1'b1;
    en = 1'b1;
    cyc(2);

    for (int f = 0; f < 6; f++) begin
      frame(4'b0000);
      phase = 11 + f;
      cyc(1);
    end

    frame(4'b0000);            // A divider -> 1
    en = 1'b0;
    frame(4'b0000);
    frame(4'b0000);
    phase = 20;
    cyc(1);
    en = 1'b1;
    frame(4'b0000);
    phase = 21;
    cyc(1);

    en = 1'b0;
    hit = 4'b1000; cyc(1);
    hit = '0;
    phase = 30;
    cyc(1);
    en = 1'b1;

    frame(4'b0000);            // A divider -> 1
    frame(4'b0001);            // hit coincides with A's update
    phase = 31;
    cyc(1);
    frame(4'b0000);            // A divider -> 1
    hit = 4'b0001; cyc(1);     // clears A's divider
    hit = '0; cyc(1);
    frame(4'b0000);
    phase = 33;
    cyc(1);
    frame(4'b0000);
    phase = 34;
    cyc(1);

    yy = 10'd470; cyc(2);
    yy = 10'd480; cyc(4);
    i_rst_n = 1'b0; cyc(2);
    phase = 40;
    cyc(1);
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      phase = 41 + k;
    end
    cyc(1);
    yy = 10'd481; cyc(2);
    yy = 10'd480; cyc(1);
    phase = 50;
    cyc(1);
    phase = 51;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Per-frame motion sequencer for the bee sprite. It owns the sprite's top-left position and steps it once per N video frames: horizontal sweep, bounce at the screen edges with a downward drop, and a terminal "landed" state. Position outputs feed the sprite pixel/address generator, replacing its fixed start coordinates, and change only during vertical blanking so a frame is never drawn with a torn sprite.

## Interface
Parameters:
- X_START, 300: x position after reset or respawn.
- Y_START, 100: y position after reset or respawn.
- SPR_W, 34: sprite width in pixels.
- SCREEN_W, 640: visible width; the rightmost legal x is SCREEN_W-SPR_W (606).
- SCREEN_H, 480: visible height; frame tick on yy entering this line.
- STEP_X, 2: horizontal pixels per update.
- STEP_Y, 8: vertical pixels per drop.
- Y_LIMIT, 400: y at which the sprite lands.
- FRAME_DIV, 2: frames per update, ≥1.

Ports:
- i_clk  in  1  system clock (100 MHz); all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- xx  in  10  current VGA column.
- yy  in  10  current VGA row.
- i_enable  in  1  1 = motion runs; 0 = position holds, divider holds.
- i_hit  in  1  single-cycle pulse: sprite destroyed, respawn.
- o_spr_x  out  10  sprite left column.
- o_spr_y  out  10  sprite top row.
- o_dir_left  out  1  1 = currently moving left.
- o_landed  out  1  1 = sprite reached Y_LIMIT.
- o_frame_tick  out  1  one-cycle pulse per frame.

## Operation
- Frame tick: register yy_d each cycle; tick = (yy == SCREEN_H) && (yy_d != SCREEN_H). Exactly one tick per frame regardless of pixel/clock ratio.
- Divider: counts ticks while i_enable; on count == FRAME_DIV-1 and tick, it wraps to 0 and issues an update.
- FSM states: MOVE_R, MOVE_L, DROP_R, DROP_L, LANDED. Reset state MOVE_R.
- MOVE_R on update: if x+STEP_X ≥ SCREEN_W-SPR_W then x ← SCREEN_W-SPR_W, go DROP_L; else x ← x+STEP_X.
- MOVE_L on update: if x ≤ STEP_X then x ← 0, go DROP_R; else x ← x−STEP_X.
- DROP_L / DROP_R on update: if y+STEP_Y ≥ Y_LIMIT then y ← Y_LIMIT, go LANDED; else y ← y+STEP_Y, go MOVE_L / MOVE_R respectively. x unchanged.
- LANDED: no motion; o_landed = 1; exit only via i_hit or reset.
- i_hit has priority over everything, including a coincident update and i_enable = 0: x ← X_START, y ← Y_START, state ← MOVE_R, divider ← 0.
- o_dir_left = 1 in MOVE_L and DROP_R (drop-before-right still reports left until the turn), 0 otherwise.
- Arithmetic: 11-bit intermediate sums so x+STEP_X never wraps; comparisons unsigned.

## Timing
- Reset values: o_spr_x = X_START, o_spr_y = Y_START, o_dir_left = 0, o_landed = 0, o_frame_tick = 0, divider = 0, yy_d = 0.
- o_frame_tick asserts the cycle after yy first equals SCREEN_H, for one cycle.
- Position and state update on the cycle after the qualifying o_frame_tick (2 cycles after yy reaches SCREEN_H); all within blanking.
- i_hit: outputs reflect respawn the next cycle.
- i_enable low: ticks still pulse; divider and position frozen; resumes from the held divider count.
- Reset mid-frame: the next tick occurs on the next yy entry into SCREEN_H, with no spurious tick from yy_d = 0.

## Structure
- Shared package/header: screen constants (SCREEN_W, SCREEN_H) and FSM state encodings, reused by future sprite controllers.
- One natural sub-module: frame_tick_gen (yy edge detect + FRAME_DIV divider), instanced per controller.

## Test plan
- Reset, then run 4 frames with FRAME_DIV = 2 → x = 300, 300, 302, 302, 304 after each tick; y = 100; o_dir_left = 0.
- Force x near edge: start X_START = 604 → first update x = 606, state DROP_L; next update y = 108, o_dir_left = 1; next update x = 604.
- Left edge: X_START = 1 in MOVE_L → x = 0, then drop y += 8, then x = 2 moving right.
- Landing: Y_START = 396 at a drop → y = 400, o_landed = 1; further frames hold all outputs.
- i_hit coincident with update and with i_enable = 0 in LANDED → next cycle x = 300, y = 100, o_landed = 0, state MOVE_R, divider 0.
- Assert i_rst_n low mid-frame with yy = 480 held → outputs at reset values; no o_frame_tick until yy leaves and re-enters 480.
